// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, instruction
// field positions, default address width and the fetch FSM state type.
package instruction_fetch_pkg;

  localparam int ADDR_W_DEFAULT = 10;

  localparam logic [5:0] OP_JUMP = 6'b010100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000110;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int JTGT_HI = 25;
  localparam int JTGT_LO = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  function automatic logic is_jump(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO] == OP_JUMP;
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Next-PC priority select: hold on fault, redirect, hold on stall,
// jump, else sequential increment (wraps modulo 2^ADDR_W).
module fetch_pc_next #(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_fault_hold,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_stall,
  input  logic              i_is_jump,
  input  logic [ADDR_W-1:0] i_jump_target,
  output logic [ADDR_W-1:0] o_pc_next
);

  always_comb begin
    o_pc_next = i_pc + ADDR_W'(1);
    if (i_fault_hold) begin
      o_pc_next = i_pc;
    end else if (i_branch_taken) begin
      o_pc_next = i_branch_target;
    end else if (i_stall) begin
      o_pc_next = i_pc;
    end else if (i_is_jump) begin
      o_pc_next = i_jump_target;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, RUN/FAULT sequencing and the IF/ID
// pipeline register. Memory read is combinational off the live PC.
//
//   state    | meaning
//   ST_RUN   | fetching normally
//   ST_FAULT | PC left the legal range; frozen until reset
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int MEM_WORDS = 81,
  parameter int RESET_PC  = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] address,
  input  logic [31:0]       instrucao,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output logic              fetch_fault
);

  localparam logic [ADDR_W:0] LP_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_pc_oob;
  logic              w_fault_hold;

  assign address     = r_pc;
  assign fetch_fault = (r_state == ST_FAULT);
  assign w_pc_oob    = ({1'b0, r_pc} >= LP_LIMIT);

  // An out-of-range PC is forgiven only if this same edge redirects away.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_RUN && w_pc_oob && !branch_taken) begin
      w_state_next = ST_FAULT;
    end
  end

  assign w_fault_hold = (w_state_next == ST_FAULT);

  fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .i_pc            (r_pc),
    .i_fault_hold    (w_fault_hold),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_stall         (stall),
    .i_is_jump       (is_jump(instrucao)),
    .i_jump_target   (instrucao[JTGT_LO +: ADDR_W]),
    .o_pc_next       (w_pc_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_pc    <= ADDR_W'(RESET_PC);
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_instr <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (w_fault_hold || branch_taken) begin
      if_valid <= 1'b0;
    end else if (!stall) begin
      if_instr <= instrucao;
      if_pc    <= r_pc;
      if_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, jump, stall,
// branch/flush, fault entry and exit, and asynchronous reset.
module tb_instruction_fetch;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] address;
  logic [31:0]   instrucao;
  logic [31:0]   if_instr;
  logic [AW-1:0] if_pc;
  logic          if_valid;
  logic          fetch_fault;

  logic [31:0] mem [0:1023];
  int total = 0;
  int bad   = 0;

  instruction_fetch #(.ADDR_W(AW), .MEM_WORDS(81), .RESET_PC(0)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .address       (address),
    .instrucao     (instrucao),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .fetch_fault   (fetch_fault)
  );

  always #5 clock = ~clock;
  assign instrucao = mem[address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input int a, input int pc, input logic [31:0] ins,
                         input logic v, input logic f);
    chk({tag, ".address"}, 32'(address), 32'(a));
    if (v) begin
      chk({tag, ".if_pc"}, 32'(if_pc), 32'(pc));
      chk({tag, ".if_instr"}, if_instr, ins);
    end
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(v));
    chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'(f));
  endtask

  function automatic logic [31:0] seqw(input int i);
    return 32'h0100_0000 | 32'(i);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = seqw(i);
    mem[6] = {6'b010100, 26'd2};
    mem[7] = {6'b010100, 26'd90};

    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #12;
    chk("rst.address", 32'(address), 32'd0);
    chk("rst.if_instr", if_instr, 32'd0);
    chk("rst.if_pc", 32'(if_pc), 32'd0);
    chk("rst.if_valid", 32'(if_valid), 32'd0);
    chk("rst.fetch_fault", 32'(fetch_fault), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Sequential fetch: if_pc 0..4, address one ahead
    for (int n = 0; n < 5; n++) begin
      edge1();
      chk_out($sformatf("seq%0d", n), n + 1, n, seqw(n), 1'b1, 1'b0);
    end

    // Jump at word 6 to 2: addresses 5,6,2,3
    edge1(); chk_out("jmp.a", 6, 5, seqw(5), 1'b1, 1'b0);
    edge1(); chk_out("jmp.b", 2, 6, {6'b010100, 26'd2}, 1'b1, 1'b0);
    edge1(); chk_out("jmp.c", 3, 2, seqw(2), 1'b1, 1'b0);

    // Stall three cycles at PC=3
    stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      edge1();
      chk_out($sformatf("stall%0d", n), 3, 2, seqw(2), 1'b1, 1'b0);
    end
    stall = 1'b0;
    edge1(); chk_out("resume", 4, 3, seqw(3), 1'b1, 1'b0);

    // Branch with stall at PC=4: redirect wins, flush
    branch_taken = 1'b1; branch_target = 10'd1; stall = 1'b1;
    edge1(); chk_out("brst", 1, 0, 32'd0, 1'b0, 1'b0);
    branch_taken = 1'b0; stall = 1'b0;
    edge1(); chk_out("brst.after", 2, 1, seqw(1), 1'b1, 1'b0);

    // Redirect to last legal word, then to 81 escaped by a branch in the same cycle
    branch_taken = 1'b1; branch_target = 10'd80;
    edge1(); chk_out("br80", 80, 0, 32'd0, 1'b0, 1'b0);
    branch_taken = 1'b0;
    edge1(); chk_out("w80", 81, 80, seqw(80), 1'b1, 1'b0);
    branch_taken = 1'b1; branch_target = 10'd5;
    edge1(); chk_out("oob.escape", 5, 0, 32'd0, 1'b0, 1'b0);

    branch_taken = 1'b1; branch_target = 10'd80;
    edge1();
    branch_taken = 1'b0;
    edge1(); chk_out("w80b", 81, 80, seqw(80), 1'b1, 1'b0);
    edge1(); chk_out("fault", 81, 0, 32'd0, 1'b0, 1'b1);

    // Fault ignores branch and stall
    branch_taken = 1'b1; branch_target = 10'd3; stall = 1'b1;
    edge1(); chk_out("fault.hold", 81, 0, 32'd0, 1'b0, 1'b1);
    branch_taken = 1'b0; stall = 1'b0;

    // Async reset between edges clears fault immediately
    #2; reset_n = 1'b0; #1;
    chk_out("arst.fault", 0, 0, 32'd0, 1'b0, 1'b0);
    chk("arst.if_pc", 32'(if_pc), 32'd0);
    chk("arst.if_instr", if_instr, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    edge1(); chk_out("post.rst", 1, 0, seqw(0), 1'b1, 1'b0);
    edge1(); chk_out("post.rst2", 2, 1, seqw(1), 1'b1, 1'b0);

    // Async reset mid-run
    #2; reset_n = 1'b0; #1;
    chk_out("arst.run", 0, 0, 32'd0, 1'b0, 1'b0);
    chk("arst.run.if_pc", 32'(if_pc), 32'd0);
    @(negedge clock); reset_n = 1'b1;

    // Jump to out-of-range target: accepted, fault once PC gets there
    branch_taken = 1'b1; branch_target = 10'd7;
    edge1(); chk_out("br7", 7, 0, 32'd0, 1'b0, 1'b0);
    branch_taken = 1'b0;
    edge1(); chk_out("jmp90", 90, 7, {6'b010100, 26'd90}, 1'b1, 1'b0);
    edge1(); chk_out("fault90", 90, 0, 32'd0, 1'b0, 1'b1);
    edge1(); chk_out("fault90.hold", 90, 0, 32'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
